// File: rtl/sdc_read_sequencer.sv
// SD block-read sequencer: drives CMD17/CMD18/CMD12 through the command engine
// and supervises the data receiver frame by frame.
module sdc_read_sequencer #(
   parameter int BLKSIZE_W = 12,
   parameter int BLKCNT_W  = 16,
   parameter int TIMEOUT_W = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [31:0]          blkAddr,
   input  logic [BLKCNT_W-1:0]  blkCount,
   input  logic [BLKSIZE_W-1:0] blkSize,
   input  logic                 wideBusIn,
   input  logic [TIMEOUT_W-1:0] timeout,
   output logic                 busy,
   output logic                 done,
   output logic [4:0]           errFlags,
   output logic                 cmd_req,
   output logic [5:0]           cmd_index,
   output logic [31:0]          cmd_arg,
   input  logic                 cmd_ack,
   input  logic                 cmd_done,
   input  logic                 cmd_err,
   output logic [BLKSIZE_W-1:0] rxSize,
   output logic                 wideBus,
   output logic                 rx_rst,
   input  logic                 rx_idle,
   input  logic                 rx_last,
   input  logic                 rx_crcError,
   input  logic                 rx_frameError
);

   typedef enum logic [3:0] {
      IDLE, SEND_CMD, WAIT_CMD, WAIT_START, RECEIVE,
      CHECK, SEND_STOP, WAIT_STOP, DONE
   } state_t;

   state_t               state_q;
   logic                 busy_q, done_q, rx_rst_q, cmd_req_q;
   logic [4:0]           err_q;
   logic [5:0]           cmd_idx_q;
   logic [31:0]          cmd_arg_q;
   logic [BLKSIZE_W-1:0] rxsize_q;
   logic                 wide_q, multi_q, pend_q;
   logic [BLKCNT_W-1:0]  left_q;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic                 blk_crc_q, blk_frame_q, blk_last_q;
   logic                 expire, abort_hit, blk_bad, wrap_up;

   // wrap_up: this cycle ends the data phase (CMD12 if multi, else DONE)
   always_comb begin
      cnt_d     = cnt_q - TIMEOUT_W'(1);
      expire    = (state_q == WAIT_START) && (timeout != '0) && (cnt_d == '0);
      abort_hit = abort && (state_q inside {WAIT_START, RECEIVE, CHECK});
      blk_bad   = blk_crc_q | blk_frame_q | ~blk_last_q;
      wrap_up   = abort_hit | expire |
                  ((state_q == CHECK) && (blk_bad || left_q == BLKCNT_W'(1)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rx_rst_q    <= 1'b0;
         cmd_req_q   <= 1'b0;
         err_q       <= '0;
         cmd_idx_q   <= '0;
         cmd_arg_q   <= '0;
         rxsize_q    <= '0;
         wide_q      <= 1'b0;
         multi_q     <= 1'b0;
         pend_q      <= 1'b0;
         left_q      <= '0;
         cnt_q       <= '0;
         blk_crc_q   <= 1'b0;
         blk_frame_q <= 1'b0;
         blk_last_q  <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         rx_rst_q <= 1'b0;
         unique case (state_q)
            IDLE: if (start) begin
               rxsize_q  <= blkSize;
               wide_q    <= wideBusIn;
               left_q    <= (blkCount == '0) ? BLKCNT_W'(1) : blkCount;
               multi_q   <= blkCount > BLKCNT_W'(1);
               err_q     <= '0;
               pend_q    <= 1'b0;
               busy_q    <= 1'b1;
               cmd_req_q <= 1'b1;
               cmd_idx_q <= (blkCount > BLKCNT_W'(1)) ? 6'd18 : 6'd17;
               cmd_arg_q <= blkAddr;
               state_q   <= SEND_CMD;
            end
            SEND_CMD: begin
               if (abort) begin
                  pend_q   <= 1'b1;
                  err_q[4] <= 1'b1;
               end
               if (cmd_ack) begin
                  cmd_req_q <= 1'b0;
                  state_q   <= WAIT_CMD;
               end
            end
            WAIT_CMD: begin
               if (abort) begin
                  pend_q   <= 1'b1;
                  err_q[4] <= 1'b1;
               end
               if (cmd_done) begin
                  if (cmd_err || pend_q || abort) begin
                     err_q[0] <= err_q[0] | cmd_err;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     cnt_q   <= timeout;
                     state_q <= WAIT_START;
                  end
               end else if (!rx_idle && !pend_q && !abort) begin
                  blk_crc_q   <= rx_crcError;
                  blk_frame_q <= rx_frameError;
                  blk_last_q  <= rx_last;
                  state_q     <= RECEIVE;
               end
            end
            WAIT_START: begin
               if (abort) begin
                  rx_rst_q <= 1'b1;
                  err_q[4] <= 1'b1;
               end else if (expire) begin
                  rx_rst_q <= 1'b1;
                  err_q[1] <= 1'b1;
               end else if (!rx_idle) begin
                  blk_crc_q   <= rx_crcError;
                  blk_frame_q <= rx_frameError;
                  blk_last_q  <= rx_last;
                  state_q     <= RECEIVE;
               end else if (timeout != '0) begin
                  cnt_q <= cnt_d;
               end
            end
            RECEIVE: begin
               if (abort) begin
                  rx_rst_q <= 1'b1;
                  err_q[4] <= 1'b1;
               end else begin
                  blk_crc_q   <= blk_crc_q | rx_crcError;
                  blk_frame_q <= blk_frame_q | rx_frameError;
                  blk_last_q  <= blk_last_q | rx_last;
                  if (rx_idle) state_q <= CHECK;
               end
            end
            CHECK: begin
               err_q[3] <= err_q[3] | blk_frame_q;
               err_q[2] <= err_q[2] | blk_crc_q;
               left_q   <= left_q - BLKCNT_W'(1);
               if (abort) begin
                  rx_rst_q <= 1'b1;
                  err_q[4] <= 1'b1;
               end else if (!wrap_up) begin
                  cnt_q   <= timeout;
                  state_q <= WAIT_START;
               end
            end
            SEND_STOP: begin
               if (abort) err_q[4] <= 1'b1;
               if (cmd_ack) begin
                  cmd_req_q <= 1'b0;
                  state_q   <= WAIT_STOP;
               end
            end
            WAIT_STOP: begin
               if (abort) err_q[4] <= 1'b1;
               if (cmd_done) begin
                  if (cmd_err) err_q[0] <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         if (wrap_up) begin
            if (multi_q) begin
               cmd_req_q <= 1'b1;
               cmd_idx_q <= 6'd12;
               cmd_arg_q <= '0;
               state_q   <= SEND_STOP;
            end else begin
               done_q  <= 1'b1;
               state_q <= DONE;
            end
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign errFlags  = err_q;
   assign cmd_req   = cmd_req_q;
   assign cmd_index = cmd_idx_q;
   assign cmd_arg   = cmd_arg_q;
   assign rxSize    = rxsize_q;
   assign wideBus   = wide_q;
   assign rx_rst    = rx_rst_q;

endmodule

// File: tb/tb_sdc_read_sequencer.sv
// Directed bench for sdc_read_sequencer: a hand-driven command engine and
// receiver exercise single/multi reads, errors, timeout, abort and reset.
module tb_sdc_read_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, abort = 1'b0;
   logic [31:0] blkAddr = '0;
   logic [15:0] blkCount = '0;
   logic [11:0] blkSize = '0;
   logic        wideBusIn = 1'b0;
   logic [23:0] timeout = '0;
   logic        busy, done, cmd_req, wideBus, rx_rst;
   logic [4:0]  errFlags;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [11:0] rxSize;
   logic        cmd_ack = 1'b0, cmd_done = 1'b0, cmd_err = 1'b0;
   logic        rx_idle = 1'b1, rx_last = 1'b0;
   logic        rx_crcError = 1'b0, rx_frameError = 1'b0;

   int tests = 0;
   int fails = 0;
   int n12 = 0;
   logic req_prev = 1'b0;

   sdc_read_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .blkAddr(blkAddr), .blkCount(blkCount), .blkSize(blkSize),
      .wideBusIn(wideBusIn), .timeout(timeout), .busy(busy), .done(done),
      .errFlags(errFlags), .cmd_req(cmd_req), .cmd_index(cmd_index),
      .cmd_arg(cmd_arg), .cmd_ack(cmd_ack), .cmd_done(cmd_done),
      .cmd_err(cmd_err), .rxSize(rxSize), .wideBus(wideBus),
      .rx_rst(rx_rst), .rx_idle(rx_idle), .rx_last(rx_last),
      .rx_crcError(rx_crcError), .rx_frameError(rx_frameError)
   );

   always #5 clk = ~clk;

   // counts CMD12 requests issued
   always @(posedge clk) begin
      if (cmd_req && !req_prev && cmd_index == 6'd12) n12 <= n12 + 1;
      req_prev <= cmd_req;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] a, input logic [15:0] c,
                           input logic [11:0] s, input logic w,
                           input logic [23:0] t);
      blkAddr = a; blkCount = c; blkSize = s; wideBusIn = w; timeout = t;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic cmd_xact(input logic err, output bit ok,
                           output logic [5:0] idx, output logic [31:0] arg,
                           output logic req_after);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (cmd_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      idx = cmd_index;
      arg = cmd_arg;
      req_after = 1'b1;
      if (ok) begin
         cmd_ack = 1'b1;
         tick();
         cmd_ack = 1'b0;
         req_after = cmd_req;
         tick();
         cmd_done = 1'b1;
         cmd_err = err;
         tick();
         cmd_done = 1'b0;
         cmd_err = 1'b0;
      end
   endtask

   task automatic rx_frame(input int len, input logic crc, input logic frm,
                           input logic last);
      rx_idle = 1'b1;
      tick();
      rx_idle = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (i == len - 1) begin
            rx_last = last; rx_crcError = crc; rx_frameError = frm;
         end
         tick();
      end
      rx_idle = 1'b1; rx_last = 1'b0; rx_crcError = 1'b0; rx_frameError = 1'b0;
      tick();
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      tests++;
      if ({busy, done, errFlags, cmd_req, cmd_index, cmd_arg, rxSize, wideBus, rx_rst} !== '0) begin
         fails++;
         $display("FAIL reset_outputs busy=%b done=%b err=%b req=%b idx=%0d arg=%h size=%0d wide=%b rxrst=%b, all required 0",
                  busy, done, errFlags, cmd_req, cmd_index, cmd_arg, rxSize, wideBus, rx_rst);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single;
      bit ok; logic [5:0] idx; logic [31:0] arg; logic ra; int s;
      s = n12;
      do_start(32'h0000_1234, 16'd1, 12'd511, 1'b1, 24'd0);
      tests++;
      if ({busy, cmd_req} !== 2'b11) begin
         fails++; $display("FAIL single_busy_req got %b required 11", {busy, cmd_req});
      end
      tests++;
      if ({rxSize, wideBus} !== {12'd511, 1'b1}) begin
         fails++; $display("FAIL single_rxcfg got %0d/%b required 511/1", rxSize, wideBus);
      end
      cmd_xact(1'b0, ok, idx, arg, ra);
      tests++;
      if ({ok, idx, arg, ra} !== {1'b1, 6'd17, 32'h1234, 1'b0}) begin
         fails++; $display("FAIL single_cmd ok=%b idx=%0d arg=%h req=%b required 1/17/1234/0", ok, idx, arg, ra);
      end
      rx_frame(4, 1'b0, 1'b0, 1'b1);
      wait_done(ok);
      tests++;
      if ({ok, errFlags} !== {1'b1, 5'b0}) begin
         fails++; $display("FAIL single_done ok=%b err=%b required 1/00000", ok, errFlags);
      end
      tick();
      tests++;
      if ({done, busy, n12 - s} !== {1'b0, 1'b0, 32'd0}) begin
         fails++; $display("FAIL single_end done=%b busy=%b cmd12=%0d required 0/0/0", done, busy, n12 - s);
      end
   endtask

   task automatic test_zero_count;
      bit ok, ok2; logic [5:0] idx; logic [31:0] arg; logic ra; int s;
      s = n12;
      do_start(32'h55, 16'd0, 12'd63, 1'b0, 24'd0);
      cmd_xact(1'b0, ok, idx, arg, ra);
      rx_frame(2, 1'b0, 1'b0, 1'b1);
      wait_done(ok2);
      tests++;
      if ({ok, idx, ok2, errFlags, n12 - s} !== {1'b1, 6'd17, 1'b1, 5'b0, 32'd0}) begin
         fails++; $display("FAIL zero_count ok=%b idx=%0d done=%b err=%b cmd12=%0d required 1/17/1/0/0",
                           ok, idx, ok2, errFlags, n12 - s);
      end
      tick();
   endtask

   task automatic test_multi;
      bit ok; logic [5:0] idx; logic [31:0] arg; logic ra; int s;
      s = n12;
      do_start(32'h0000_00AB, 16'd3, 12'd255, 1'b0, 24'd0);
      cmd_xact(1'b0, ok, idx, arg, ra);
      tests++;
      if ({ok, idx, arg} !== {1'b1, 6'd18, 32'hAB}) begin
         fails++; $display("FAIL multi_cmd ok=%b idx=%0d arg=%h required 1/18/ab", ok, idx, arg);
      end
      do_start(32'h0000_0999, 16'd1, 12'd100, 1'b1, 24'd0);
      tests++;
      if ({rxSize, wideBus} !== {12'd255, 1'b0}) begin
         fails++; $display("FAIL multi_start_ignored got %0d/%b required 255/0", rxSize, wideBus);
      end
      for (int b = 0; b < 3; b++) rx_frame(3, 1'b0, 1'b0, 1'b1);
      cmd_xact(1'b0, ok, idx, arg, ra);
      tests++;
      if ({ok, idx, arg} !== {1'b1, 6'd12, 32'h0}) begin
         fails++; $display("FAIL multi_stop ok=%b idx=%0d arg=%h required 1/12/0", ok, idx, arg);
      end
      wait_done(ok);
      tests++;
      if ({ok, errFlags, n12 - s} !== {1'b1, 5'b0, 32'd1}) begin
         fails++; $display("FAIL multi_done ok=%b err=%b cmd12=%0d required 1/00000/1", ok, errFlags, n12 - s);
      end
      tick();
   endtask

   task automatic test_crc;
      bit ok; logic [5:0] idx; logic [31:0] arg; logic ra; int s;
      s = n12;
      do_start(32'h10, 16'd4, 12'd511, 1'b1, 24'd0);
      cmd_xact(1'b0, ok, idx, arg, ra);
      rx_frame(3, 1'b0, 1'b0, 1'b1);
      rx_frame(3, 1'b1, 1'b0, 1'b1);
      cmd_xact(1'b0, ok, idx, arg, ra);
      tests++;
      if ({ok, idx} !== {1'b1, 6'd12}) begin
         fails++; $display("FAIL crc_stop ok=%b idx=%0d required 1/12", ok, idx);
      end
      wait_done(ok);
      tests++;
      if ({ok, errFlags, n12 - s} !== {1'b1, 5'b00100, 32'd1}) begin
         fails++; $display("FAIL crc_done ok=%b err=%b cmd12=%0d required 1/00100/1", ok, errFlags, n12 - s);
      end
      tick();
   endtask

   task automatic test_timeout;
      bit ok; logic [5:0] idx; logic [31:0] arg; logic ra; int s, n;
      s = n12;
      do_start(32'h20, 16'd1, 12'd511, 1'b0, 24'd100);
      cmd_xact(1'b0, ok, idx, arg, ra);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         n++;
         if (rx_rst) break;
      end
      tests++;
      if ({rx_rst, done, errFlags} !== {1'b1, 1'b1, 5'b00010} || n != 100) begin
         fails++; $display("FAIL timeout_single rxrst=%b done=%b err=%b cycles=%0d required 1/1/00010/100",
                           rx_rst, done, errFlags, n);
      end
      tick();
      tests++;
      if ({rx_rst, busy, n12 - s} !== {1'b0, 1'b0, 32'd0}) begin
         fails++; $display("FAIL timeout_after rxrst=%b busy=%b cmd12=%0d required 0/0/0", rx_rst, busy, n12 - s);
      end
      do_start(32'h21, 16'd2, 12'd511, 1'b0, 24'd7);
      cmd_xact(1'b0, ok, idx, arg, ra);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         n++;
         if (rx_rst) break;
      end
      tests++;
      if ({rx_rst, cmd_req, cmd_index} !== {1'b1, 1'b1, 6'd12} || n != 7) begin
         fails++; $display("FAIL timeout_multi rxrst=%b req=%b idx=%0d cycles=%0d required 1/1/12/7",
                           rx_rst, cmd_req, cmd_index, n);
      end
      cmd_xact(1'b0, ok, idx, arg, ra);
      wait_done(ok);
      tests++;
      if ({ok, errFlags} !== {1'b1, 5'b00010}) begin
         fails++; $display("FAIL timeout_multi_done ok=%b err=%b required 1/00010", ok, errFlags);
      end
      tick();
   endtask

   task automatic test_cmd_err;
      bit ok; logic [5:0] idx; logic [31:0] arg; logic ra; int s;
      s = n12;
      do_start(32'h30, 16'd2, 12'd511, 1'b0, 24'd0);
      cmd_xact(1'b1, ok, idx, arg, ra);
      tests++;
      if ({ok, idx, done, errFlags} !== {1'b1, 6'd18, 1'b1, 5'b00001}) begin
         fails++; $display("FAIL cmd_err ok=%b idx=%0d done=%b err=%b required 1/18/1/00001",
                           ok, idx, done, errFlags);
      end
      for (int i = 0; i < 4; i++) tick();
      tests++;
      if ({busy, cmd_req, n12 - s} !== {1'b0, 1'b0, 32'd0}) begin
         fails++; $display("FAIL cmd_err_after busy=%b req=%b cmd12=%0d required 0/0/0", busy, cmd_req, n12 - s);
      end
   endtask

   task automatic test_abort;
      bit ok; logic [5:0] idx; logic [31:0] arg; logic ra;
      do_start(32'h40, 16'd3, 12'd511, 1'b0, 24'd0);
      cmd_xact(1'b0, ok, idx, arg, ra);
      rx_frame(3, 1'b0, 1'b0, 1'b1);
      rx_idle = 1'b1;
      tick();
      rx_idle = 1'b0;
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tests++;
      if ({rx_rst, cmd_req, cmd_index, errFlags} !== {1'b1, 1'b1, 6'd12, 5'b10000}) begin
         fails++; $display("FAIL abort_rx rxrst=%b req=%b idx=%0d err=%b required 1/1/12/10000",
                           rx_rst, cmd_req, cmd_index, errFlags);
      end
      rx_idle = 1'b1;
      tick();
      tests++;
      if (rx_rst !== 1'b0) begin
         fails++; $display("FAIL abort_rxrst_pulse got %b required 0", rx_rst);
      end
      cmd_xact(1'b0, ok, idx, arg, ra);
      wait_done(ok);
      tests++;
      if ({ok, errFlags} !== {1'b1, 5'b10000}) begin
         fails++; $display("FAIL abort_done ok=%b err=%b required 1/10000", ok, errFlags);
      end
      tick();
   endtask

   task automatic test_reset_mid;
      bit ok; logic [5:0] idx; logic [31:0] arg; logic ra; int s;
      do_start(32'h50, 16'd3, 12'd511, 1'b1, 24'd0);
      cmd_xact(1'b0, ok, idx, arg, ra);
      rx_idle = 1'b0;
      tick();
      tick();
      s = n12;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({busy, done, errFlags, cmd_req, cmd_index, cmd_arg, rxSize, wideBus, rx_rst} !== '0) begin
         fails++; $display("FAIL reset_mid busy=%b req=%b size=%0d wide=%b, all required 0",
                           busy, cmd_req, rxSize, wideBus);
      end
      rx_idle = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tests++;
      if ({busy, cmd_req, n12 - s} !== {1'b0, 1'b0, 32'd0}) begin
         fails++; $display("FAIL reset_mid_after busy=%b req=%b cmd12=%0d required 0/0/0", busy, cmd_req, n12 - s);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_zero_count();
      test_multi();
      test_crc();
      test_timeout();
      test_cmd_err();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
